button_port: RTL

Memory-mapped input peripheral answering CPU data-bus reads and writes decoded by the MMU. It is the read-side counterpart to the MMU's write-only seven-segment output.
- Synchronises and debounces the board's active-low push buttons.
- Records press/release events in sticky write-1-to-clear registers.
- Optionally raises a level interrupt for the CPU.

---
 rtl/coffee_pkg.sv | 12 +
 rtl/button_debounce.sv | 46 ++++
 rtl/button_port.sv | 96 +++++++++
 3 files changed

// File: rtl/coffee_pkg.sv
// Shared constants for the CPU data-bus peripherals: register offsets, bus width, base address.
package coffee_pkg;
    localparam int DATA_W = 32;

    localparam logic [1:0] BTN_STATE    = 2'd0;
    localparam logic [1:0] BTN_PRESS    = 2'd1;
    localparam logic [1:0] BTN_RELEASE  = 2'd2;
    localparam logic [1:0] BTN_IRQ_MASK = 2'd3;

    // MMU decode window for the button port
    localparam logic [DATA_W-1:0] BTN_BASE_ADDR = 32'h0000_0020;
endpackage

// File: rtl/button_debounce.sv
// Purpose: 2-flop synchroniser + stability counter for one active-low button.
// Latency: level change accepted DEBOUNCE_CYCLES+2 edges after a stable raw change.
// Backpressure: none; rise/fall are single-cycle pulses on the toggle edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_n,
    output logic state,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          pressed_sync;
    logic          differ;
    logic          toggle;

    assign pressed_sync = ~sync[1];
    assign differ       = pressed_sync != state;
    assign toggle       = differ && (cnt == LAST);
    assign rise         = toggle && !state;
    assign fall         = toggle && state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b11;
            cnt   <= '0;
            state <= 1'b0;
        end else begin
            sync <= {sync[0], button_n};
            if (toggle) begin
                state <= ~state;
                cnt   <= '0;
            end else if (differ) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/button_port.sv
// Purpose: debounced push-button peripheral with sticky W1C press/release registers; BUTTON_PORT_IRQ_EN adds mask + irq.
// Latency: reads return on the edge after sel; irq follows PRESS/IRQ_MASK by one edge.
// Backpressure: none; an access may be issued every cycle with no wait states.
module button_port
    import coffee_pkg::*;
#(
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel,
    input  logic [1:0]           addr,
    input  logic                 wr_en,
    input  logic [DATA_W-1:0]    wr_data,
    output logic [DATA_W-1:0]    rd_data,
    input  logic [N_BUTTONS-1:0] buttons_n,
    output logic                 irq
);
    logic [N_BUTTONS-1:0] state;
    logic [N_BUTTONS-1:0] rise;
    logic [N_BUTTONS-1:0] fall;
    logic [N_BUTTONS-1:0] press_bits;
    logic [N_BUTTONS-1:0] release_bits;
    logic [N_BUTTONS-1:0] mask_bits;
    logic [N_BUTTONS-1:0] press_clr;
    logic [N_BUTTONS-1:0] release_clr;
    logic [DATA_W-1:0]    rd_next;
    logic                 wr_hit;
    logic                 unused_wr;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .button_n (buttons_n[i]),
            .state    (state[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    assign wr_hit      = sel && wr_en;
    assign press_clr   = (wr_hit && addr == BTN_PRESS)   ? wr_data[N_BUTTONS-1:0] : '0;
    assign release_clr = (wr_hit && addr == BTN_RELEASE) ? wr_data[N_BUTTONS-1:0] : '0;
    assign unused_wr   = ^wr_data[DATA_W-1:N_BUTTONS];

    // Set is ORed in after the clear so a same-edge event wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_bits   <= '0;
            release_bits <= '0;
        end else begin
            press_bits   <= (press_bits & ~press_clr) | rise;
            release_bits <= (release_bits & ~release_clr) | fall;
        end
    end

`ifdef BUTTON_PORT_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_bits <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_hit && addr == BTN_IRQ_MASK) begin
                mask_bits <= wr_data[N_BUTTONS-1:0];
            end
            irq <= |(press_bits & mask_bits);
        end
    end
`else
    assign mask_bits = '0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        rd_next = '0;
        case (addr)
            BTN_STATE:    rd_next[N_BUTTONS-1:0] = state;
            BTN_PRESS:    rd_next[N_BUTTONS-1:0] = press_bits;
            BTN_RELEASE:  rd_next[N_BUTTONS-1:0] = release_bits;
            BTN_IRQ_MASK: rd_next[N_BUTTONS-1:0] = mask_bits;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (sel && !wr_en) begin
            rd_data <= rd_next;
        end
    end
endmodule
